// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM-stage
// load/store path. Data accesses win over fetch. Each access runs
// IDLE -> DATA|FETCH -> RESP. Wait states are absorbed through mem_ready_i,
// and an optional timeout aborts an access that the memory never completes.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        dm_read_i,
   input  logic        dm_write_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [3:0]  dm_be_i,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        if_valid_o,
   output logic [31:0] if_rdata_o,
   output logic        dm_valid_o,
   output logic [31:0] dm_rdata_o,
   output logic        if_stall_o,
   output logic        dm_stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

   // Last counter value before abort; guarded so TIMEOUT=0 does not underflow.
   localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TO_LAST);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             dm_req;
   logic             timed_out;
   logic             done;

   assign dm_req    = dm_read_i | dm_write_i;
   assign timed_out = (TIMEOUT != 0) && !mem_ready_i && (cnt == TO_CNT);
   assign done      = mem_ready_i | timed_out;

   // Stalls depend only on requests and the registered valids, never on mem_ready_i.
   assign if_stall_o = if_req_i & ~if_valid_o;
   assign dm_stall_o = dm_req & ~dm_valid_o;

   // State register.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic. The data request takes priority because the MEM-stage instruction is older.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dm_req)        state_nxt = DATA;
            else if (if_req_i) state_nxt = FETCH;
         end
         DATA, FETCH: if (done) state_nxt = RESP;
         RESP:        state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Memory bus, response registers and wait counter.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         if_valid_o  <= 1'b0;
         if_rdata_o  <= '0;
         dm_valid_o  <= 1'b0;
         dm_rdata_o  <= '0;
         err_o       <= 1'b0;
         cnt         <= '0;
      end else begin
         if_valid_o <= 1'b0;
         dm_valid_o <= 1'b0;
         err_o      <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dm_req) begin
                  // Read and write both asserted is treated as a write.
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dm_write_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
                  mem_be_o    <= dm_write_i ? dm_be_i : 4'hF;
               end else if (if_req_i) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  mem_be_o    <= 4'hF;
               end
            end
            DATA, FETCH: begin
               if (done) begin
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
                  err_o     <= timed_out;
                  if (state == DATA) begin
                     dm_valid_o <= 1'b1;
                     // Stores and aborted accesses return zero.
                     dm_rdata_o <= (mem_ready_i && !mem_we_o) ? mem_rdata_i : 32'h0;
                  end else begin
                     if_valid_o <= 1'b1;
                     if_rdata_o <= mem_ready_i ? mem_rdata_i : 32'h0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected completions
// into a queue; a monitor pops one on every valid pulse and compares.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        nRESET;
   logic        if_req_i, dm_read_i, dm_write_i, mem_ready_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
   logic [3:0]  dm_be_i;
   logic        mem_req_o, mem_we_o, if_valid_o, dm_valid_o, if_stall_o, dm_stall_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o;
   logic [3:0]  mem_be_o;

   typedef struct {
      logic        is_if;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
      .CLK(CLK), .nRESET(nRESET),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
      .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
      .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
      .if_stall_o(if_stall_o), .dm_stall_o(dm_stall_o), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic is_if, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.is_if = is_if;
      e.rdata = rdata;
      e.err   = err;
      q.push_back(e);
   endtask

   // Monitor: every completion pulse must match the oldest expected entry.
   always @(negedge CLK) begin
      if (nRESET && (if_valid_o || dm_valid_o)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: if_valid=%b dm_valid=%b with empty queue", if_valid_o, dm_valid_o);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_if_valid", {31'b0, if_valid_o}, {31'b0, e.is_if});
            chk("resp_dm_valid", {31'b0, dm_valid_o}, {31'b0, !e.is_if});
            chk("resp_rdata", e.is_if ? if_rdata_o : dm_rdata_o, e.rdata);
            chk("resp_err", {31'b0, err_o}, {31'b0, e.err});
         end
      end
   end

   initial begin
      nRESET = 1'b0;
      if_req_i = 0; dm_read_i = 0; dm_write_i = 0; mem_ready_i = 0;
      if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0; dm_be_i = 0;
      repeat (2) @(posedge CLK);
      #1;
      // Reset state
      chk("rst_mem_req", {31'b0, mem_req_o}, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_be", {28'b0, mem_be_o}, 0);
      chk("rst_valids", {30'b0, if_valid_o, dm_valid_o}, 0);
      chk("rst_rdata", if_rdata_o | dm_rdata_o, 0);
      chk("rst_err", {31'b0, err_o}, 0);
      nRESET = 1'b1;
      cyc();

      // Zero-wait load
      dm_read_i = 1; dm_addr_i = 32'h100; mem_ready_i = 1; mem_rdata_i = 32'hDEADBEEF;
      push(1'b0, 32'hDEADBEEF, 1'b0);
      #1 chk("ld0_stall_c0", {31'b0, dm_stall_o}, 1);
      cyc();
      chk("ld0_req_c1", {31'b0, mem_req_o}, 1);
      chk("ld0_addr", mem_addr_o, 32'h100);
      chk("ld0_we", {31'b0, mem_we_o}, 0);
      chk("ld0_be", {28'b0, mem_be_o}, 32'hF);
      chk("ld0_stall_c1", {31'b0, dm_stall_o}, 1);
      chk("ld0_valid_c1", {31'b0, dm_valid_o}, 0);
      cyc();
      chk("ld0_req_c2", {31'b0, mem_req_o}, 0);
      chk("ld0_valid_c2", {31'b0, dm_valid_o}, 1);
      chk("ld0_stall_c2", {31'b0, dm_stall_o}, 0);
      dm_read_i = 0; mem_ready_i = 0;
      cyc();

      // Store with 3 wait states
      dm_write_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'h12345678; dm_be_i = 4'b0011;
      mem_rdata_i = 32'hFFFF0000;
      push(1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         if (i == 4) mem_ready_i = 1;
         chk("st_req", {31'b0, mem_req_o}, 1);
         chk("st_we", {31'b0, mem_we_o}, 1);
         chk("st_addr", mem_addr_o, 32'h200);
         chk("st_wdata", mem_wdata_o, 32'h12345678);
         chk("st_be", {28'b0, mem_be_o}, 32'h3);
         chk("st_stall", {31'b0, dm_stall_o}, 1);
      end
      cyc();
      chk("st_req_c5", {31'b0, mem_req_o}, 0);
      chk("st_valid_c5", {31'b0, dm_valid_o}, 1);
      chk("st_stall_c5", {31'b0, dm_stall_o}, 0);
      dm_write_i = 0; mem_ready_i = 0;
      cyc();

      // Simultaneous fetch and load: data first
      if_req_i = 1; if_addr_i = 32'h40; dm_read_i = 1; dm_addr_i = 32'h300;
      mem_ready_i = 1; mem_rdata_i = 32'hA5A5A5A5;
      push(1'b0, 32'hA5A5A5A5, 1'b0);
      cyc();
      chk("pri_addr", mem_addr_o, 32'h300);
      chk("pri_if_stall_c1", {31'b0, if_stall_o}, 1);
      cyc();
      dm_read_i = 0; mem_rdata_i = 32'h00000013;
      push(1'b1, 32'h00000013, 1'b0);
      chk("pri_req_resp", {31'b0, mem_req_o}, 0);
      chk("pri_if_stall_c2", {31'b0, if_stall_o}, 1);
      cyc();
      chk("pri_if_stall_c3", {31'b0, if_stall_o}, 1);
      chk("pri_req_idle", {31'b0, mem_req_o}, 0);
      cyc();
      chk("pri_fetch_req", {31'b0, mem_req_o}, 1);
      chk("pri_fetch_addr", mem_addr_o, 32'h40);
      chk("pri_if_stall_c4", {31'b0, if_stall_o}, 1);
      cyc();
      chk("pri_if_valid", {31'b0, if_valid_o}, 1);
      chk("pri_if_stall_c5", {31'b0, if_stall_o}, 0);
      if_req_i = 0; mem_ready_i = 0;
      cyc();

      // Fetch timeout
      if_req_i = 1; if_addr_i = 32'h80; mem_ready_i = 0; mem_rdata_i = 32'h00000BAD;
      push(1'b1, 32'h0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("to_req", {31'b0, mem_req_o}, 1);
      end
      cyc();
      chk("to_req_end", {31'b0, mem_req_o}, 0);
      chk("to_err", {31'b0, err_o}, 1);
      chk("to_if_stall", {31'b0, if_stall_o}, 0);
      if_req_i = 0;
      cyc();
      chk("to_err_clear", {31'b0, err_o}, 0);

      // Reset mid-access
      dm_read_i = 1; dm_addr_i = 32'h400; mem_ready_i = 0;
      cyc();
      cyc();
      chk("rm_req_before", {31'b0, mem_req_o}, 1);
      #2 nRESET = 1'b0;
      #1;
      chk("rm_req_async", {31'b0, mem_req_o}, 0);
      chk("rm_addr_async", mem_addr_o, 0);
      chk("rm_be_async", {28'b0, mem_be_o}, 0);
      cyc();
      chk("rm_req_held", {31'b0, mem_req_o}, 0);
      nRESET = 1'b1;
      mem_ready_i = 1; mem_rdata_i = 32'h0BADF00D;
      push(1'b0, 32'h0BADF00D, 1'b0);
      cyc();
      chk("rm_req_fresh", {31'b0, mem_req_o}, 1);
      chk("rm_addr_fresh", mem_addr_o, 32'h400);
      cyc();
      chk("rm_valid", {31'b0, dm_valid_o}, 1);
      dm_read_i = 0; mem_ready_i = 0;
      cyc();

      // Back-to-back fetches, ready pulse in RESP ignored
      if_req_i = 1;
      for (int k = 0; k < 3; k++) begin
         if_addr_i = 32'h1000 + 32'(4 * k); mem_ready_i = 0;
         chk("b2b_idle_req", {31'b0, mem_req_o}, 0);
         cyc();
         mem_ready_i = 1; mem_rdata_i = 32'h11 * 32'(k + 1);
         push(1'b1, 32'h11 * 32'(k + 1), 1'b0);
         chk("b2b_fetch_req", {31'b0, mem_req_o}, 1);
         chk("b2b_fetch_addr", mem_addr_o, 32'h1000 + 32'(4 * k));
         cyc();
         mem_ready_i = 1; mem_rdata_i = 32'hEEEEEEEE;
         chk("b2b_resp_req", {31'b0, mem_req_o}, 0);
         chk("b2b_resp_valid", {31'b0, if_valid_o}, 1);
         cyc();
      end
      if_req_i = 0; mem_ready_i = 0;
      cyc();
      chk("b2b_quiet", {31'b0, mem_req_o}, 0);
      cyc();

      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port unified memory between instruction fetch (IF) and the MEM stage load/store.
- The MEM stage side is driven from the EX/MEM pipeline register outputs: MemRead, MemWrite, ALUresult as address, RDdata as store data.
- Handles wait-state memory (ready handshake) and bus timeout.
- Generates stall signals that freeze PC, IF/ID, ID/EX and EX/MEM until the access completes.

Parameters:
- TIMEOUT, 16: maximum cycles an access may wait for mem_ready_i before abort. 0 disables the timeout.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock.
- nRESET  in  1  reset; asynchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  32  fetch address (PC).
- dm_read_i  in  1  load request (EX_MEM MemRead).
- dm_write_i  in  1  store request (EX_MEM MemWrite).
- dm_addr_i  in  32  load/store address (EX_MEM ALUresult).
- dm_wdata_i  in  32  store data (EX_MEM RDdata).
- dm_be_i  in  4  store byte enables.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_rdata_i  in  32  memory read data, valid when mem_ready_i=1.
- mem_req_o  out  1  access in progress.
- mem_we_o  out  1  write access.
- mem_addr_o  out  32  access address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables; 4'hF for fetch and load.
- if_valid_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  32  fetched instruction.
- dm_valid_o  out  1  one-cycle load/store completion pulse.
- dm_rdata_o  out  32  load data.
- if_stall_o  out  1  if_req_i & ~if_valid_o (combinational).
- dm_stall_o  out  1  (dm_read_i|dm_write_i) & ~dm_valid_o (combinational).
- err_o  out  1  one-cycle pulse, coincident with the valid pulse, when an access timed out.

Behaviour:
- Reset: state=IDLE; all registered outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_valid_o, if_rdata_o, dm_valid_o, dm_rdata_o, err_o); wait counter 0.
- Reset mid-access drops mem_req_o immediately. The memory must tolerate an abandoned request.
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE:
  - If dm_read_i|dm_write_i: go to DATA. Register mem_addr_o=dm_addr_i, mem_we_o=dm_write_i, mem_wdata_o=dm_wdata_i, mem_be_o=dm_write_i?dm_be_i:4'hF.
  - Else if if_req_i: go to FETCH with mem_addr_o=if_addr_i, mem_we_o=0, mem_be_o=4'hF.
  - Fixed priority: data beats fetch, because the MEM instruction is older.
  - If dm_read_i and dm_write_i are both 1, treat as a write.
- DATA/FETCH:
  - mem_req_o=1. Address, data, we and be are held stable.
  - The wait counter increments each cycle mem_ready_i=0.
  - On mem_ready_i=1: capture mem_rdata_i into dm_rdata_o (load) or if_rdata_o (fetch). A store loads dm_rdata_o with 0. Then go to RESP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready_i=0: abort, go to RESP, load rdata 0, set err_o.
- RESP (exactly 1 cycle):
  - mem_req_o=0; the matching valid is 1; err_o as latched.
  - No new access is issued, so the EX/MEM stage cannot re-request the same instruction while it advances.
  - Go to IDLE; valid and err_o clear; counter clears.
- Latency: zero-wait access gives the valid pulse 2 cycles after the request is sampled in IDLE. Each wait state adds 1 cycle. The minimum spacing between access starts is 3 cycles.
- Requester inputs are sampled only in IDLE. Changes during DATA/FETCH/RESP are ignored.
- If a requester drops its request before completion, the access still completes and the valid pulse is still issued.
- mem_rdata_i is ignored when mem_ready_i=0. mem_ready_i is ignored outside DATA/FETCH.
- The stall outputs are combinational from the inputs and registered valids. There is no path from mem_ready_i to any stall output.

Test Plan:
- Zero-wait load: dm_read_i=1, addr 0x100; mem_ready_i=1 in first DATA cycle with rdata 0xDEADBEEF -> dm_valid_o=1 and dm_rdata_o=0xDEADBEEF 2 cycles after request; dm_stall_o high 2 cycles then low; mem_req_o high exactly 1 cycle.
- Store with 3 wait states: dm_write_i=1, addr 0x200, wdata 0x12345678, be 4'b0011 -> mem_we_o=1 and fields stable for 4 mem_req_o cycles; dm_valid_o at cycle 5; dm_rdata_o=0.
- Simultaneous if_req_i and dm_read_i in IDLE -> DATA served first; FETCH starts the cycle after RESP; if_stall_o stays high until if_valid_o.
- Timeout: TIMEOUT=4, fetch with mem_ready_i held 0 -> mem_req_o high 4 cycles; then if_valid_o=1, err_o=1, if_rdata_o=0 for one cycle.
- Reset mid-access: nRESET low during the DATA wait -> mem_req_o and all outputs 0 asynchronously; after release, a fresh load completes normally.
- Back-to-back fetches with if_req_i held: accesses start every 3 cycles; a mem_ready_i pulse during RESP is ignored.
